timer_countdown_core: RTL and testbench

- Sequential countdown engine of the digital timer.
- Holds the 8-bit remaining-time value and decrements it once per prescaled tick.
- Drives the binary-to-BCD converter's 8-bit input directly via o_count.
- Exposes run/pause/expire status and a one-cycle done pulse for the alarm/LED logic.

---
 rtl/timer_countdown_core.sv | 129 ++++++++++++
 tb/tb_timer_countdown_core.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_countdown_core.sv
// Countdown engine of the digital timer: holds the remaining count, decrements it once per
// prescaled tick and reports run/pause/expire status plus a one-cycle done pulse.
module timer_countdown_core #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned MAX_COUNT = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_start,
    input  logic       i_pause,
    output logic [7:0] o_count,
    output logic [1:0] o_state,
    output logic       o_done,
    output logic       o_expired
);

    localparam int unsigned CW = 8;
    localparam int unsigned PW = $clog2(TICK_DIV);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] COUNT_MAX  = CW'(MAX_COUNT);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          expired_q, expired_d;
    logic [CW-1:0] load_eff;
    logic          tick;

    assign load_eff = (i_load_val > COUNT_MAX) ? COUNT_MAX : i_load_val;
    assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    // Command priority: clear > load > start > pause.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        if (i_clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    if (i_load) begin
                        count_d = load_eff;
                    end else if (i_start && (count_q != '0)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_load) begin
                        count_d = load_eff;
                        presc_d = '0;
                        state_d = (load_eff != '0) ? ST_RUN : ST_IDLE;
                    end else begin
                        presc_d = tick ? '0 : presc_q + PW'(1);
                        // Decrement first; an expiring tick overrides a same-cycle pause.
                        if (tick && (count_q <= CW'(1))) begin
                            count_d = '0;
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            if (tick) begin
                                count_d = count_q - CW'(1);
                            end
                            if (i_pause) begin
                                state_d = ST_PAUSED;
                            end
                        end
                    end
                end
                ST_PAUSED: begin
                    if (i_load) begin
                        count_d = load_eff;
                        presc_d = '0;
                        state_d = ST_IDLE;
                    end else if (i_start || i_pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    presc_d = '0;
                    count_d = '0;
                    if (i_load) begin
                        count_d = load_eff;
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end

        expired_d = (state_d == ST_EXPIRED);
    end

    assign o_count   = count_q;
    assign o_state   = state_q;
    assign o_done    = done_q;
    assign o_expired = expired_q;

endmodule

// File: tb/tb_timer_countdown_core.sv
// Bench for timer_countdown_core with TICK_DIV=4, MAX_COUNT=99: stimulus table plus hand sequences.
module tb_timer_countdown_core;

    typedef struct {
        logic [7:0] cnt;
        logic [1:0] st;
        logic       done;
        logic       exp;
    } obs_t;

    typedef struct {
        logic       clr;
        logic       ld;
        logic [7:0] val;
        logic       st;
        logic       pa;
        obs_t       e;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic       start;
    logic       pause;
    logic [7:0] count;
    logic [1:0] state;
    logic       done;
    logic       expired;

    int   n_cmp;
    int   n_err;
    obs_t exp_q[$];
    vec_t tbl[$];

    timer_countdown_core #(.TICK_DIV(4), .MAX_COUNT(99)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clear    (clear),
        .i_load     (load),
        .i_load_val (load_val),
        .i_start    (start),
        .i_pause    (pause),
        .o_count    (count),
        .o_state    (state),
        .o_done     (done),
        .o_expired  (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t ob(input logic [7:0] c, input logic [1:0] s, input logic d, input logic x);
        obs_t o;
        o.cnt  = c;
        o.st   = s;
        o.done = d;
        o.exp  = x;
        return o;
    endfunction

    function automatic vec_t mk(input logic clr, input logic ld, input logic [7:0] val,
                                input logic st, input logic pa, input obs_t e);
        vec_t v;
        v.clr = clr;
        v.ld  = ld;
        v.val = val;
        v.st  = st;
        v.pa  = pa;
        v.e   = e;
        return v;
    endfunction

    task automatic add(input vec_t v, input int n);
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic check_out(input string tag);
        obs_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty when output sampled", tag);
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if (count !== e.cnt || state !== e.st || done !== e.done || expired !== e.exp) begin
                n_err++;
                $display("FAIL %s @%0t: got cnt=%0d st=%0d done=%0b exp=%0b, want cnt=%0d st=%0d done=%0b exp=%0b",
                         tag, $time, count, state, done, expired, e.cnt, e.st, e.done, e.exp);
            end
        end
    endtask

    // One command cycle: drive after the falling edge, sample just after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        clear    = v.clr;
        load     = v.ld;
        load_val = v.val;
        start    = v.st;
        pause    = v.pa;
        exp_q.push_back(v.e);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic nop(input int n, input obs_t e, input string tag);
        for (int i = 0; i < n; i++) apply(mk(0, 0, 8'd0, 0, 0, e), tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 8'd0;
        start    = 1'b0;
        pause    = 1'b0;

        #23;
        exp_q.push_back(ob(8'd0, 2'd0, 1'b0, 1'b0));
        check_out("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle commands, saturation, normal countdown, expired behaviour
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd0,  2'd0, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   1, 0, ob(8'd0,  2'd0, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   0, 1, ob(8'd0,  2'd0, 0, 0)), 1);
        add(mk(0, 1, 8'd200, 0, 0, ob(8'd99, 2'd0, 0, 0)), 1);
        add(mk(0, 1, 8'd0,   0, 0, ob(8'd0,  2'd0, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   1, 0, ob(8'd0,  2'd0, 0, 0)), 1);
        add(mk(0, 1, 8'd5,   1, 0, ob(8'd5,  2'd0, 0, 0)), 1);
        add(mk(0, 1, 8'd3,   0, 0, ob(8'd3,  2'd0, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   1, 0, ob(8'd3,  2'd1, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd3,  2'd1, 0, 0)), 3);
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd2,  2'd1, 0, 0)), 4);
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd1,  2'd1, 0, 0)), 4);
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd0,  2'd3, 1, 1)), 1);
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd0,  2'd3, 0, 1)), 2);
        add(mk(0, 0, 8'd0,   1, 0, ob(8'd0,  2'd3, 0, 1)), 1);
        add(mk(0, 0, 8'd0,   0, 1, ob(8'd0,  2'd3, 0, 1)), 1);
        add(mk(0, 1, 8'd12,  0, 0, ob(8'd12, 2'd0, 0, 0)), 1);
        // Clear in RUN, clear beating load
        add(mk(0, 1, 8'd9,   0, 0, ob(8'd9,  2'd0, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   1, 0, ob(8'd9,  2'd1, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd9,  2'd1, 0, 0)), 2);
        add(mk(1, 0, 8'd0,   0, 0, ob(8'd0,  2'd0, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd0,  2'd0, 0, 0)), 1);
        add(mk(0, 1, 8'd20,  0, 0, ob(8'd20, 2'd0, 0, 0)), 1);
        add(mk(1, 1, 8'd50,  0, 0, ob(8'd0,  2'd0, 0, 0)), 1);
        // Reload while running restarts the prescaler; load 0 returns to IDLE
        add(mk(0, 1, 8'd4,   0, 0, ob(8'd4,  2'd0, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   1, 0, ob(8'd4,  2'd1, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd4,  2'd1, 0, 0)), 1);
        add(mk(0, 1, 8'd7,   0, 0, ob(8'd7,  2'd1, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd7,  2'd1, 0, 0)), 3);
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd6,  2'd1, 0, 0)), 1);
        add(mk(0, 1, 8'd0,   0, 0, ob(8'd0,  2'd0, 0, 0)), 1);
        // Pause on the final tick: expiry wins
        add(mk(0, 1, 8'd1,   0, 0, ob(8'd1,  2'd0, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   1, 0, ob(8'd1,  2'd1, 0, 0)), 1);
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd1,  2'd1, 0, 0)), 3);
        add(mk(0, 0, 8'd0,   0, 1, ob(8'd0,  2'd3, 1, 1)), 1);
        add(mk(0, 0, 8'd0,   0, 0, ob(8'd0,  2'd3, 0, 1)), 1);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("table[%0d]", i));

        // Pause/resume keeps the partial prescaler period
        apply(mk(0, 1, 8'd5, 0, 0, ob(8'd5, 2'd0, 0, 0)), "pr_load");
        apply(mk(0, 0, 8'd0, 1, 0, ob(8'd5, 2'd1, 0, 0)), "pr_start");
        nop(3, ob(8'd5, 2'd1, 0, 0), "pr_run5");
        nop(2, ob(8'd4, 2'd1, 0, 0), "pr_run4");
        apply(mk(0, 0, 8'd0, 0, 1, ob(8'd4, 2'd2, 0, 0)), "pr_pause");
        nop(20, ob(8'd4, 2'd2, 0, 0), "pr_hold");
        apply(mk(0, 0, 8'd0, 1, 0, ob(8'd4, 2'd1, 0, 0)), "pr_resume");
        nop(1, ob(8'd4, 2'd1, 0, 0), "pr_after1");
        nop(4, ob(8'd3, 2'd1, 0, 0), "pr_cnt3");
        nop(4, ob(8'd2, 2'd1, 0, 0), "pr_cnt2");
        nop(4, ob(8'd1, 2'd1, 0, 0), "pr_cnt1");
        nop(1, ob(8'd0, 2'd3, 1, 1), "pr_expire");
        nop(1, ob(8'd0, 2'd3, 0, 1), "pr_expired");

        // Pause toggles back to RUN; load while paused returns to IDLE
        apply(mk(0, 1, 8'd2, 0, 0, ob(8'd2, 2'd0, 0, 0)), "pt_load");
        apply(mk(0, 0, 8'd0, 1, 0, ob(8'd2, 2'd1, 0, 0)), "pt_start");
        apply(mk(0, 0, 8'd0, 0, 1, ob(8'd2, 2'd2, 0, 0)), "pt_pause");
        apply(mk(0, 0, 8'd0, 0, 1, ob(8'd2, 2'd1, 0, 0)), "pt_toggle");
        apply(mk(0, 0, 8'd0, 0, 1, ob(8'd2, 2'd2, 0, 0)), "pt_pause2");
        apply(mk(0, 1, 8'd8, 0, 0, ob(8'd8, 2'd0, 0, 0)), "pt_reload");

        // Asynchronous reset mid-run, checked before any clock edge
        apply(mk(0, 1, 8'd7, 0, 0, ob(8'd7, 2'd0, 0, 0)), "rs_load");
        apply(mk(0, 0, 8'd0, 1, 0, ob(8'd7, 2'd1, 0, 0)), "rs_start");
        nop(1, ob(8'd7, 2'd1, 0, 0), "rs_run");
        @(negedge clk);
        start = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(ob(8'd0, 2'd0, 1'b0, 1'b0));
        check_out("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        nop(1, ob(8'd0, 2'd0, 0, 0), "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
